// File: rtl/da_lut_loader_if.sv
// Tap stream and coefficient-SRAM load port of the DA LUT loader.
// The master side is the tap source / DA core side; the slave side is the
// loader itself, which accepts taps and drives the LUT write port.
interface da_lut_loader_if;
  logic        tap_valid;
  logic [15:0] tap_data;
  logic        tap_ready;
  logic [19:0] CIN;
  logic [10:0] CADDR;
  logic        CLOAD;
  logic        busy;
  logic        done;

  modport master (
    output tap_valid,
    output tap_data,
    input  tap_ready,
    input  CIN,
    input  CADDR,
    input  CLOAD,
    input  busy,
    input  done
  );

  modport slave (
    input  tap_valid,
    input  tap_data,
    output tap_ready,
    output CIN,
    output CADDR,
    output CLOAD,
    output busy,
    output done
  );
endinterface

// File: rtl/da_lut_loader.sv
// da_lut_loader: collects 64 signed 16-bit FIR taps and writes the 2048
// distributed-arithmetic partial sums (8 banks x 256 entries, 20-bit signed)
// into the DA core's coefficient SRAM. Within a bank the entries are walked
// in Gray-code order so that every step changes exactly one address bit and
// the running sum needs a single add or subtract per written entry.

// Output invariants of the loader, kept apart from the datapath.
module da_lut_loader_chk (
  input logic clk,
  input logic resetn,
  input logic tap_ready,
  input logic cload,
  input logic busy,
  input logic done
);
  // Writes only happen while the loader reports itself busy.
  a_cload_busy: assert property (@(posedge clk) disable iff (!resetn)
    cload |-> busy);

  // The completion pulse comes after the last write, never alongside one.
  a_done_idle: assert property (@(posedge clk) disable iff (!resetn)
    done |-> (!cload && !busy));

  // Taps are accepted exactly when the loader is not generating.
  a_ready_idle: assert property (@(posedge clk) disable iff (!resetn)
    tap_ready == !busy);
endmodule

module da_lut_loader (
  input  logic           clk,
  input  logic           resetn,
  da_lut_loader_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_t;

  // Index of the lowest set bit; this is the address bit that flips when the
  // Gray sequence steps from n-1 to n. Returns 0 for a zero input.
  function automatic logic [2:0] tz8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r = 3'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Binary-reflected Gray code of the step counter.
  function automatic logic [7:0] gray8(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  // Sign-extend a tap to the entry width.
  function automatic logic signed [19:0] sext20(input logic [15:0] t);
    return {{4{t[15]}}, t};
  endfunction

  // Registered state
  state_t             state_r;
  logic [5:0]         tap_cnt_r;
  logic [2:0]         bank_r;
  logic [7:0]         n_r;
  logic signed [19:0] sum_r;
  logic [19:0]        cin_r;
  logic [10:0]        caddr_r;
  logic               cload_r;
  logic               done_r;
  logic               busy_r;
  logic [15:0]        taps_r [64];

  // Next-state values
  state_t             state_s;
  logic [5:0]         tap_cnt_s;
  logic [2:0]         bank_s;
  logic [7:0]         n_s;
  logic signed [19:0] sum_s;
  logic [19:0]        cin_s;
  logic [10:0]        caddr_s;
  logic               cload_s;
  logic               done_s;
  logic               busy_s;
  logic               tap_we_s;

  // Gray-step datapath
  logic               tap_ready_s;
  logic               accept_s;
  logic               last_s;
  logic [7:0]         nxt_n_s;
  logic [2:0]         nxt_bank_s;
  logic [7:0]         gray_s;
  logic [2:0]         step_bit_s;
  logic signed [19:0] tap_ext_s;
  logic signed [19:0] step_sum_s;

  assign tap_ready_s = (state_r == ST_IDLE);
  assign accept_s    = bus.tap_valid & tap_ready_s;

  assign bus.tap_ready = tap_ready_s;
  assign bus.CIN       = cin_r;
  assign bus.CADDR     = caddr_r;
  assign bus.CLOAD     = cload_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // Work out the entry that follows the one currently on the load port:
  // advance the step counter, find the flipped bit and fold that tap in.
  always_comb begin
    last_s     = (bank_r == 3'd7) && (n_r == 8'd255);
    nxt_n_s    = n_r + 8'd1;
    if (n_r == 8'd255) begin
      nxt_bank_s = bank_r + 3'd1;
    end else begin
      nxt_bank_s = bank_r;
    end
    gray_s     = gray8(nxt_n_s);
    step_bit_s = tz8(nxt_n_s);
    tap_ext_s  = sext20(taps_r[{nxt_bank_s, step_bit_s}]);
    if (nxt_n_s == 8'd0) begin
      // New bank: its entry 0 is the empty sum.
      step_sum_s = 20'sd0;
    end else if (gray_s[step_bit_s]) begin
      step_sum_s = sum_r + tap_ext_s;
    end else begin
      step_sum_s = sum_r - tap_ext_s;
    end
  end

  // Next-state and output logic of the collect/generate controller.
  always_comb begin
    state_s   = state_r;
    tap_cnt_s = tap_cnt_r;
    bank_s    = bank_r;
    n_s       = n_r;
    sum_s     = sum_r;
    cin_s     = cin_r;
    caddr_s   = caddr_r;
    cload_s   = 1'b0;
    done_s    = 1'b0;
    busy_s    = 1'b0;
    tap_we_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          tap_we_s = 1'b1;
          if (tap_cnt_r == 6'd63) begin
            // Last tap: present entry 0 of bank 0 on the next cycle.
            state_s   = ST_GEN;
            tap_cnt_s = 6'd0;
            bank_s    = 3'd0;
            n_s       = 8'd0;
            sum_s     = 20'sd0;
            cin_s     = 20'd0;
            caddr_s   = 11'd0;
            cload_s   = 1'b1;
            busy_s    = 1'b1;
          end else begin
            tap_cnt_s = tap_cnt_r + 6'd1;
          end
        end else begin
          tap_cnt_s = tap_cnt_r;
        end
      end

      ST_GEN: begin
        if (last_s) begin
          // Final entry is on the port this cycle; wrap up the session.
          state_s   = ST_IDLE;
          tap_cnt_s = 6'd0;
          bank_s    = 3'd0;
          n_s       = 8'd0;
          sum_s     = 20'sd0;
          done_s    = 1'b1;
        end else begin
          n_s     = nxt_n_s;
          bank_s  = nxt_bank_s;
          sum_s   = step_sum_s;
          cin_s   = step_sum_s;
          caddr_s = {nxt_bank_s, gray_s};
          cload_s = 1'b1;
          busy_s  = 1'b1;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        tap_cnt_s = 6'd0;
        bank_s    = 3'd0;
        n_s       = 8'd0;
        sum_s     = 20'sd0;
      end
    endcase
  end

  // Controller state and registered load-port outputs; reset drops CLOAD at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      tap_cnt_r <= 6'd0;
      bank_r    <= 3'd0;
      n_r       <= 8'd0;
      sum_r     <= 20'sd0;
      cin_r     <= 20'd0;
      caddr_r   <= 11'd0;
      cload_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      tap_cnt_r <= tap_cnt_s;
      bank_r    <= bank_s;
      n_r       <= n_s;
      sum_r     <= sum_s;
      cin_r     <= cin_s;
      caddr_r   <= caddr_s;
      cload_r   <= cload_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
    end
  end

  // Tap register file: each accepted tap lands at its arrival index.
  always_ff @(posedge clk) begin
    if (tap_we_s) begin
      taps_r[tap_cnt_r] <= bus.tap_data;
    end
  end

  da_lut_loader_chk u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .tap_ready (tap_ready_s),
    .cload     (cload_r),
    .busy      (busy_r),
    .done      (done_r)
  );

endmodule

// File: doc/da_lut_loader.md
# da_lut_loader

Coefficient-table writer for the distributed-arithmetic FIR core: accepts 64 signed 16-bit filter taps over a valid/ready stream, then generates all 2048 DA partial-sum entries and writes them into the core's coefficient SRAM through its CIN/CADDR/CLOAD load port. It drives the write side of the LUT that the DA core reads. Entries are computed incrementally in Gray-code order, so each entry costs one add or subtract and one write cycle.

## Interface
- No parameters; tap count 64, tap width 16, entry width 20, 8 banks × 256 entries fixed.
- clk  input  1  sole clock, all state on posedge.
- resetn  input  1  asynchronous, active-low reset.
- tap_valid  input  1  tap_data is valid this cycle.
- tap_data  input  16  signed tap h[n], two's complement, delivered in order n = 0..63.
- tap_ready  output  1  loader accepts a tap this cycle; high only in IDLE.
- CIN  output  20  signed LUT entry to write.
- CADDR  output  11  write address {bank[2:0], k[7:0]}.
- CLOAD  output  1  write strobe, one entry per cycle while high.
- busy  output  1  high in GEN.
- done  output  1  one-cycle pulse after the last write.

## Operation
- Entry definition: bank j (0..7), index k (0..255): LUT[j][k] = Σ over set bits b of k of sext20(h[8j+b]). Address bit b of bank j corresponds to tap 8j+b. LUT[j][0] = 0.
- Width: |entry| ≤ 8·2^15 = 2^18, so 20-bit signed never overflows. No saturation logic.
- Tap storage: 64×16 register file, written at index tap_cnt[5:0] on each accepted tap (tap_valid & tap_ready).
- States:
  - IDLE: tap_ready=1, CLOAD=0, busy=0. Accept taps. On acceptance with tap_cnt==63, go to GEN, clear bank=0, n=0, sum=0.
  - GEN: tap_ready=0, busy=1. Each cycle writes one entry. tap_valid is ignored.
  - Leaving GEN: after the bank=7, n=255 write, return to IDLE with tap_cnt=0 and pulse done.
- Gray sequencing within a bank: step n = 0..255 writes address k = g(n) = n ^ (n>>1).
  - n=0: entry 0, sum cleared.
  - n>0: b = trailing-zero count of n. If g(n)[b]=1, sum += sext20(h[8j+b]); otherwise sum -= sext20(h[8j+b]).
  - sum resets to 0 at each bank boundary.
- Each address 0..2047 is written exactly once per session, bank-major in ascending bank order.

## Timing
- Reset values (asynchronous): state=IDLE, tap_cnt=0, bank=0, n=0, sum=0, CIN=0, CADDR=0, CLOAD=0, done=0, busy=0. tap_ready=1 once resetn deasserts. The tap register file is not reset.
- CIN, CADDR and CLOAD are registered. The first write (CADDR=0, CIN=0) is presented on the cycle after the edge that accepts tap 63.
- Sequencing: CLOAD stays high for exactly 2048 consecutive cycles, with a new {CADDR, CIN} each cycle, valid around the posedge the core samples.
- Completion: on the cycle after the final write, CLOAD=0, busy=0, done=1 for one cycle, tap_ready=1.
- Back-to-back sessions: a tap may be accepted in that same done cycle as tap 0 of the next session.
- Tap flow control: gaps in tap_valid stall collection indefinitely with no timeout. A partial tap set is held until completed.
- Reset mid-GEN: CLOAD drops asynchronously. The SRAM holds a partially updated table, and a full new 64-tap session is required.
- The DA core must not be started while busy=1. This is a system rule, not checked here.

## Test plan
- All taps = 1 → CADDR 0x000 → 0; 0x0FF → 8; 0x055 → 4; 0x7FF → 8. Exactly 2048 CLOAD cycles, then a single done pulse.
- h[n] = n → CADDR 0x103 (bank 1, k=3) → 8+9 = 17; 0x180 → 15; 0x7FF → Σ56..63 = 476.
- All taps = 16'h8000 → CADDR 0x0FF → 20'hC0000 (−262144); 0x001 → 20'hF8000. Confirms sign extension and no overflow.
- tap_valid toggling 1/0 for 128 cycles, then held high → exactly 64 taps accepted, tap_ready=0 through GEN. Taps offered during GEN are dropped, and the next session starts at tap_cnt=0.
- resetn pulsed low at GEN write 700 → CLOAD=0 immediately, outputs at reset values. A fresh 64-tap session then completes with a correct table, with every address checked against the reference model.
- Two back-to-back sessions with tap 0 of the second session presented in the done cycle → accepted; the second table reflects only the new taps.
